// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - Write-only character LCD controller with a command FIFO and a timed strobe sequencer
// Each queued byte is presented for SETUP, strobed for EN, held for SETUP and then followed by a settle wait.
module lcd_ctrl #(
  parameter int DEPTH        = 4,
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 12,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_busy,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAX_W = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int MAX_P = (EN_CYC > SETUP_CYC) ? EN_CYC : SETUP_CYC;
  localparam int MAXC  = (MAX_W > MAX_P) ? MAX_W : MAX_P;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q;
  logic          rs_q, en_q, on_q;
  logic          push, pop, full, clr_cmd;
  logic [CW-1:0] wait_last;

  assign full      = (count_q == (AW + 1)'(DEPTH));
  assign o_ready   = ~full & i_rst_n;
  assign push      = i_valid & o_ready;
  // Clear display / return home need the long settle time.
  assign clr_cmd   = ~rs_q & (data_q >= 8'h01) & (data_q <= 8'h03);
  assign wait_last = clr_cmd ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);

  assign o_busy     = (state_q != S_IDLE) | (count_q != '0);
  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == CW'(EN_CYC - 1)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_rs, i_data};
    end
  end

  // en is derived from the next state so the strobe comes straight off a flop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= 8'h00;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == S_PULSE);
      on_q    <= 1'b1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rs_q     <= mem_q[rd_ptr_q][8];
        data_q   <= mem_q[rd_ptr_q][7:0];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter SETUP_CYC, default 4: cycles that RS/DATA are held stable before and after EN, minimum 1.
REQ-003 SHALL have parameter EN_CYC, default 12: EN high width in cycles, minimum 1.
REQ-004 SHALL have parameter CMD_WAIT_CYC, default 2000: post-strobe wait for normal commands and data, minimum 1.
REQ-005 SHALL have parameter CLR_WAIT_CYC, default 82000: post-strobe wait for clear/home commands, minimum 1.
REQ-006 i_clk  in  1  single clock; all logic rising-edge.
REQ-007 i_rst_n  in  1  reset, synchronous, active-low.
REQ-008 i_valid  in  1  the core-side LCD write is presented.
REQ-009 i_rs  in  1  0 = instruction byte, 1 = data byte.
REQ-010 i_data  in  8  byte to send.
REQ-011 o_ready  out  1  FIFO can accept a byte.
REQ-012 o_busy  out  1  FIFO non-empty or panel transaction in progress.
REQ-013 o_lcd_data  out  8  panel data bus.
REQ-014 o_lcd_rs  out  1  panel register select.
REQ-015 o_lcd_rw  out  1  panel read/write; constant 0 (write only).
REQ-016 o_lcd_en  out  1  panel enable strobe.
REQ-017 o_lcd_on  out  1  panel power; 0 in reset, 1 otherwise.

Function
REQ-018 A byte SHALL be accepted when i_valid and o_ready are both 1 at a rising edge, storing {i_rs, i_data} at the FIFO tail.
REQ-019 o_ready SHALL equal (FIFO not full) AND i_rst_n; i_valid while full SHALL be ignored with no overwrite and no error.
REQ-020 Push and pop in the same cycle SHALL both take effect, count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-021 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-022 IDLE with FIFO non-empty: pop head and latch it into o_lcd_rs/o_lcd_data at the edge that enters SETUP; a byte accepted into an empty FIFO at edge N SHALL appear on the bus at edge N+1.
REQ-023 SETUP SHALL last SETUP_CYC cycles, en=0; PULSE SHALL last EN_CYC cycles, en=1; HOLD SHALL last SETUP_CYC cycles, en=0.
REQ-024 WAIT SHALL last CLR_WAIT_CYC cycles if the byte has rs=0 and data in 0x01..0x03, otherwise CMD_WAIT_CYC cycles; WAIT then returns to IDLE.
REQ-025 o_lcd_rs/o_lcd_data SHALL stay constant from SETUP entry until the next pop; o_lcd_en SHALL be registered and glitch-free.
REQ-026 IDLE SHALL last exactly one cycle when the FIFO is non-empty; transaction period = 1 + 2*SETUP_CYC + EN_CYC + wait.
REQ-027 o_busy SHALL be 0 only when the state is IDLE and the FIFO is empty.
REQ-028 The phase counter SHALL be sized for max(CLR_WAIT_CYC, CMD_WAIT_CYC, EN_CYC, SETUP_CYC) with no overflow.

Reset
REQ-029 With i_rst_n=0 at an edge: state IDLE, FIFO empty, counters 0, o_lcd_data=0x00, o_lcd_rs=0, o_lcd_en=0, o_lcd_on=0, o_busy=0; o_ready=0 while reset is asserted.
REQ-030 Reset asserted mid-transaction SHALL abort it: en=0 at the next edge, queued bytes discarded, no strobe after release.

Verification
REQ-031 Params SETUP=2, EN=3, CMD_WAIT=5, CLR_WAIT=20, DEPTH=4: accept rs=1, 0x41 at edge 0 -> bus=0x41, rs=1 from edge 1; en=1 for edges 3..5 only; o_busy=0 from edge 13.
REQ-032 Accept rs=0, 0x01 -> WAIT lasts 20 cycles, o_busy falls 28 cycles after acceptance; rs=0, 0x38 -> 5-cycle wait.
REQ-033 Push 6 bytes back-to-back while idle -> first 0x..
   pops next cycle, bytes 2-5 fill FIFO, o_ready=0 on the 6th push so it is dropped; exactly 5 strobes, in order, period 13 cycles.
REQ-034 Push on the same edge IDLE pops the last entry -> count stays 1, no loss, no duplication.
REQ-035 Assert reset during PULSE with 2 bytes queued -> en=0 next edge, o_busy=0, o_lcd_on=0; after release no further strobes.
REQ-036 Push 9 bytes over time with DEPTH=4 -> pointer wrap-around preserves order; checked against a scoreboard.
